// File: rtl/iq_dual_queue_if.sv
// rtl/iq_dual_queue_if.sv - decode-to-issue handshake bundle for the dual instruction queue
interface iq_dual_queue_if #(
  parameter int ENTRY_W    = 128,
  parameter int DEPTH_LOG2 = 3
);
  logic                  iq_flush;
  logic [1:0]            iq_i_valid;
  logic [ENTRY_W-1:0]    iq_i_data0;
  logic [ENTRY_W-1:0]    iq_i_data1;
  logic [1:0]            iq_o_wr_ready;
  logic [1:0]            iq_o_valid;
  logic [ENTRY_W-1:0]    iq_o_data0;
  logic [ENTRY_W-1:0]    iq_o_data1;
  logic [1:0]            iq_i_pop;
  logic [DEPTH_LOG2:0]   iq_o_count;
  logic                  iq_o_full;
  logic                  iq_o_empty;
  logic                  iq_o_afull;
  logic                  iq_o_err;

  modport master (
    output iq_flush, iq_i_valid, iq_i_data0, iq_i_data1, iq_i_pop,
    input  iq_o_wr_ready, iq_o_valid, iq_o_data0, iq_o_data1, iq_o_count,
           iq_o_full, iq_o_empty, iq_o_afull, iq_o_err
  );

  modport slave (
    input  iq_flush, iq_i_valid, iq_i_data0, iq_i_data1, iq_i_pop,
    output iq_o_wr_ready, iq_o_valid, iq_o_data0, iq_o_data1, iq_o_count,
           iq_o_full, iq_o_empty, iq_o_afull, iq_o_err
  );
endinterface

// File: rtl/iq_dual_queue.sv
// rtl/iq_dual_queue.sv - 2-wide in-order FWFT instruction queue between decode and issue
module iq_dual_queue #(
  parameter int ENTRY_W      = 128,
  parameter int DEPTH_LOG2   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic        iq_clk,
  input  logic        iq_rst,
  iq_dual_queue_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  ptr_t               r_head;
  ptr_t               r_tail;
  cnt_t               r_count;
  logic               r_err;

  logic [1:0] w_wr_ready;
  logic [1:0] w_o_valid;
  logic       w_acc0, w_acc1, w_pa0, w_pa1;
  logic       w_proto_err;
  logic [1:0] w_nacc, w_npa;
  ptr_t       w_tail1, w_head1;

  // Readiness looks only at the registered count: a same-cycle pop never frees a slot for a push.
  always_comb begin
    w_wr_ready[0] = !iq_rst && (r_count <  cnt_t'(DEPTH));
    w_wr_ready[1] = !iq_rst && (r_count <= cnt_t'(DEPTH - 2));
    w_o_valid[0]  = (r_count != '0);
    w_o_valid[1]  = (r_count >= cnt_t'(2));
  end

  assign w_acc0  = bus.iq_i_valid[0] & w_wr_ready[0];
  assign w_acc1  = bus.iq_i_valid[1] & bus.iq_i_valid[0] & w_wr_ready[1];
  assign w_pa0   = bus.iq_i_pop[0] & w_o_valid[0];
  assign w_pa1   = bus.iq_i_pop[1] & bus.iq_i_pop[0] & w_o_valid[1];
  assign w_nacc  = {1'b0, w_acc0} + {1'b0, w_acc1};
  assign w_npa   = {1'b0, w_pa0} + {1'b0, w_pa1};
  assign w_tail1 = r_tail + ptr_t'(1);
  assign w_head1 = r_head + ptr_t'(1);

  assign w_proto_err = (bus.iq_i_valid[1] & ~bus.iq_i_valid[0])
                     | (bus.iq_i_pop[1]   & ~bus.iq_i_pop[0])
                     | (bus.iq_i_pop[0]   & ~w_o_valid[0])
                     | (bus.iq_i_pop[1]   & ~w_o_valid[1]);

  always_ff @(posedge iq_clk) begin
    if (!iq_rst && !bus.iq_flush) begin
      if (w_acc0) r_mem[r_tail]  <= bus.iq_i_data0;
      if (w_acc1) r_mem[w_tail1] <= bus.iq_i_data1;
    end
  end

  always_ff @(posedge iq_clk) begin
    if (iq_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_proto_err) r_err <= 1'b1;
      if (bus.iq_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_tail  <= r_tail + ptr_t'(w_nacc);
        r_head  <= r_head + ptr_t'(w_npa);
        r_count <= r_count + cnt_t'(w_nacc) - cnt_t'(w_npa);
      end
    end
  end

  assign bus.iq_o_wr_ready = w_wr_ready;
  assign bus.iq_o_valid    = w_o_valid;
  assign bus.iq_o_data0    = w_o_valid[0] ? r_mem[r_head]  : '0;
  assign bus.iq_o_data1    = w_o_valid[1] ? r_mem[w_head1] : '0;
  assign bus.iq_o_count    = r_count;
  assign bus.iq_o_full     = (r_count == cnt_t'(DEPTH));
  assign bus.iq_o_empty    = (r_count == '0);
  assign bus.iq_o_afull    = (r_count >= cnt_t'(AFULL_THRESH));
  assign bus.iq_o_err      = r_err;
endmodule
